// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port: access sizes, arbiter states and
// the registered bus request record.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        BUS_IF   = 2'b01,
        BUS_DM   = 2'b10,
        RESP_ERR = 2'b11
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-bus signals of the shared memory port. The arbiter
// takes the slave view; the pipeline and memory side take the master view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [1:0]  dm_size;
    logic        dm_sign;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dm_misaligned;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        stall_if;
    logic        stall_mem;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_size, dm_sign, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata, dm_misaligned,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_size, dm_sign, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata, dm_misaligned,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port: store enables and replication,
// misalignment detection, and load field extraction with extension.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata_rep,
    output logic        req_misaligned,
    input  logic [1:0]  rsp_size,
    input  logic        rsp_sign,
    input  logic [1:0]  rsp_off,
    input  logic [31:0] rsp_rdata,
    output logic [31:0] rsp_data
);

    function automatic logic [31:0] ext_field(input logic [15:0] f, input logic half,
                                              input logic sgn);
        logic msb;
        msb = sgn & (half ? f[15] : f[7]);
        return half ? {{16{msb}}, f} : {{24{msb}}, f[7:0]};
    endfunction

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        req_be         = 4'b1111;
        req_wdata_rep  = req_wdata;
        req_misaligned = 1'b0;
        case (mem_size_t'(req_size))
            MEM_BYTE: begin
                req_be        = 4'b0001 << req_off;
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            MEM_HALF: begin
                req_be         = 4'b0011 << req_off;
                req_wdata_rep  = {2{req_wdata[15:0]}};
                req_misaligned = req_off[0];
            end
            MEM_WORD: begin
                req_misaligned = (req_off != 2'b00);
            end
            default: begin
                // size 11 has no legal encoding; reject it like any misaligned access
                req_misaligned = 1'b1;
            end
        endcase
    end

    always_comb begin
        byte_sel = 8'(rsp_rdata >> {rsp_off, 3'b000});
        half_sel = 16'(rsp_rdata >> {rsp_off[1], 4'b0000});
        case (mem_size_t'(rsp_size))
            MEM_BYTE: rsp_data = ext_field({8'h00, byte_sel}, 1'b0, rsp_sign);
            MEM_HALF: rsp_data = ext_field(half_sel, 1'b1, rsp_sign);
            default:  rsp_data = rsp_rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and data access: data has
// priority, a starvation counter forces fetch through, one transaction at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  port
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             if_rvalid_q, if_rvalid_d;
    logic             dm_rvalid_q, dm_rvalid_d;
    logic             dm_mis_q, dm_mis_d;

    bus_req_t         req_q, req_d;
    logic [1:0]       rsp_size_q, rsp_size_d;
    logic             rsp_sign_q, rsp_sign_d;
    logic [1:0]       rsp_off_q, rsp_off_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      dm_rdata_q, dm_rdata_d;

    logic             grant_if, grant_dm;
    logic [3:0]       dm_be;
    logic [31:0]      dm_wdata_rep;
    logic             dm_mis;
    logic [31:0]      dm_load;
    logic             bus_active;
    logic             unused_if_addr_lo;

    assign unused_if_addr_lo = ^port.if_addr[1:0];

    mem_lane_align u_align (
        .req_size       (port.dm_size),
        .req_off        (port.dm_addr[1:0]),
        .req_wdata      (port.dm_wdata),
        .req_be         (dm_be),
        .req_wdata_rep  (dm_wdata_rep),
        .req_misaligned (dm_mis),
        .rsp_size       (rsp_size_q),
        .rsp_sign       (rsp_sign_q),
        .rsp_off        (rsp_off_q),
        .rsp_rdata      (port.bus_rdata),
        .rsp_data       (dm_load)
    );

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        if_rvalid_d  = 1'b0;
        dm_rvalid_d  = 1'b0;
        dm_mis_d     = 1'b0;
        req_d        = req_q;
        rsp_size_d   = rsp_size_q;
        rsp_sign_d   = rsp_sign_q;
        rsp_off_d    = rsp_off_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        grant_if     = 1'b0;
        grant_dm     = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant_if = port.if_req & (~port.dm_req | (starve_cnt_q == CNT_MAX));
                grant_dm = port.dm_req & ~grant_if;
                if (grant_if) begin
                    starve_cnt_d = '0;
                    req_d        = '{we: 1'b0, addr: {port.if_addr[31:2], 2'b00},
                                     be: 4'b1111, wdata: 32'h0};
                    state_d      = BUS_IF;
                end else if (grant_dm) begin
                    if (port.if_req && starve_cnt_q != CNT_MAX)
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    if (dm_mis) begin
                        // rejected before any bus cycle; the response fires next cycle
                        state_d     = RESP_ERR;
                        dm_rvalid_d = 1'b1;
                        dm_mis_d    = 1'b1;
                        dm_rdata_d  = '0;
                    end else begin
                        req_d      = '{we: port.dm_we, addr: {port.dm_addr[31:2], 2'b00},
                                       be: dm_be, wdata: dm_wdata_rep};
                        rsp_size_d = port.dm_size;
                        rsp_sign_d = port.dm_sign;
                        rsp_off_d  = port.dm_addr[1:0];
                        state_d    = BUS_DM;
                    end
                end
            end
            BUS_IF: begin
                if (port.bus_ack) begin
                    if_rdata_d  = port.bus_rdata;
                    if_rvalid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            BUS_DM: begin
                if (port.bus_ack) begin
                    dm_rdata_d  = req_q.we ? 32'h0 : dm_load;
                    dm_rvalid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            RESP_ERR: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            if_rvalid_q  <= 1'b0;
            dm_rvalid_q  <= 1'b0;
            dm_mis_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            if_rvalid_q  <= if_rvalid_d;
            dm_rvalid_q  <= dm_rvalid_d;
            dm_mis_q     <= dm_mis_d;
        end
    end

    // Datapath registers carry no reset; every output they feed is gated by state or valid.
    always_ff @(posedge clk) begin
        req_q      <= req_d;
        rsp_size_q <= rsp_size_d;
        rsp_sign_q <= rsp_sign_d;
        rsp_off_q  <= rsp_off_d;
        if_rdata_q <= if_rdata_d;
        dm_rdata_q <= dm_rdata_d;
    end

    assign bus_active = (state_q == BUS_IF) || (state_q == BUS_DM);

    assign port.bus_req       = bus_active;
    assign port.bus_we        = bus_active & req_q.we;
    assign port.bus_addr      = bus_active ? req_q.addr  : 32'h0;
    assign port.bus_be        = bus_active ? req_q.be    : 4'h0;
    assign port.bus_wdata     = bus_active ? req_q.wdata : 32'h0;

    assign port.if_gnt        = grant_if;
    assign port.dm_gnt        = grant_dm;
    assign port.if_rvalid     = if_rvalid_q;
    assign port.if_rdata      = if_rvalid_q ? if_rdata_q : 32'h0;
    assign port.dm_rvalid     = dm_rvalid_q;
    assign port.dm_rdata      = dm_rvalid_q ? dm_rdata_q : 32'h0;
    assign port.dm_misaligned = dm_mis_q;

    assign port.stall_if      = (port.if_req & ~grant_if) | (state_q == BUS_IF);
    assign port.stall_mem     = (port.dm_req & ~grant_dm) | (state_q == BUS_DM);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a wait-state bus slave model, a
// response monitor popping expected results, and directed access sequences.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        mis;
    } dm_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bif();

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .port  (bif.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ack_wait = 0;
    int          wait_cnt = 0;
    logic [31:0] slave_rdata = 32'h0;

    logic [31:0] if_q[$];
    dm_exp_t     dm_q[$];

    int          bus_cycles = 0;
    logic        bus_req_prev = 1'b0;
    logic [3:0]  last_be;
    logic [31:0] last_wdata, last_addr;
    logic        last_we;
    int          gnt_cyc = 0;
    int          dm_rv_cyc = 0;
    int          dm_rv_count = 0;

    assign bif.bus_ack   = bif.bus_req && (wait_cnt == ack_wait);
    assign bif.bus_rdata = slave_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) wait_cnt <= 0;
        else if (bif.bus_req) wait_cnt <= bif.bus_ack ? 0 : wait_cnt + 1;
        else wait_cnt <= 0;
    end

    initial forever begin
        @(negedge clk);
        if (bif.bus_req) begin
            if (!bus_req_prev) bus_cycles++;
            last_be    = bif.bus_be;
            last_wdata = bif.bus_wdata;
            last_addr  = bif.bus_addr;
            last_we    = bif.bus_we;
        end
        bus_req_prev = bif.bus_req;
        if (bif.if_rvalid) begin
            if (if_q.size() == 0) chk("if_unexpected_rvalid", 32'd1, 32'd0);
            else chk("if_rdata", bif.if_rdata, if_q.pop_front());
        end
        if (bif.dm_rvalid) begin
            dm_rv_cyc = cyc;
            dm_rv_count++;
            if (dm_q.size() == 0) chk("dm_unexpected_rvalid", 32'd1, 32'd0);
            else begin
                dm_exp_t e;
                e = dm_q.pop_front();
                chk("dm_rdata", bif.dm_rdata, e.data);
                chk("dm_misaligned", 32'(bif.dm_misaligned), 32'(e.mis));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_gnt(input logic is_dm);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (is_dm ? bif.dm_gnt : bif.if_gnt) begin
                gnt_cyc = cyc;
                return;
            end
        end
        chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (if_q.size() == 0 && dm_q.size() == 0) return;
            @(negedge clk);
        end
        chk("drain_timeout", 32'(if_q.size() + dm_q.size()), 32'd0);
    endtask

    task automatic dm_acc(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] wdata, input logic [31:0] rd,
                          input logic [31:0] exp_rd, input logic exp_mis);
        dm_exp_t e;
        @(posedge clk);
        #1;
        slave_rdata  = rd;
        bif.dm_req   = 1'b1;
        bif.dm_we    = we;
        bif.dm_addr  = addr;
        bif.dm_size  = size;
        bif.dm_sign  = sgn;
        bif.dm_wdata = wdata;
        e.data = exp_rd;
        e.mis  = exp_mis;
        dm_q.push_back(e);
        wait_gnt(1'b1);
        @(posedge clk);
        #1;
        bif.dm_req = 1'b0;
        drain();
    endtask

    initial begin
        int bc0, rv0, ng, nd;
        logic if_granted;
        bif.if_req = 1'b0; bif.if_addr = '0;
        bif.dm_req = 1'b0; bif.dm_we = 1'b0; bif.dm_addr = '0;
        bif.dm_size = 2'b00; bif.dm_sign = 1'b0; bif.dm_wdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_ctrl_outs", 32'({bif.bus_req, bif.bus_we, bif.if_gnt, bif.dm_gnt, bif.if_rvalid,
            bif.dm_rvalid, bif.dm_misaligned, bif.stall_if, bif.stall_mem}), 32'd0);
        chk("rst_bus_addr", bif.bus_addr, 32'd0);
        chk("rst_rdata", bif.if_rdata | bif.dm_rdata, 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        @(posedge clk);
        #1 reset = 1'b0;

        // fetch with cycle-accurate timing on a zero-wait bus
        @(posedge clk);
        #1;
        slave_rdata = 32'h0000_0013;
        bif.if_req = 1'b1; bif.if_addr = 32'h100;
        if_q.push_back(32'h0000_0013);
        @(negedge clk);
        chk("f_gnt_c0", 32'(bif.if_gnt), 32'd1);
        chk("f_busreq_c0", 32'(bif.bus_req), 32'd0);
        @(posedge clk);
        #1 bif.if_req = 1'b0;
        @(negedge clk);
        chk("f_busreq_c1", 32'(bif.bus_req), 32'd1);
        chk("f_be_c1", 32'(bif.bus_be), 32'hF);
        chk("f_addr_c1", bif.bus_addr, 32'h100);
        chk("f_we_c1", 32'(bif.bus_we), 32'd0);
        chk("f_stall_c1", 32'(bif.stall_if), 32'd1);
        @(negedge clk);
        chk("f_rvalid_c2", 32'(bif.if_rvalid), 32'd1);
        drain();

        // both requesters held: four data grants, a forced fetch, then data again
        @(posedge clk);
        #1;
        slave_rdata = 32'hCAFE_0013;
        bif.if_req = 1'b1; bif.if_addr = 32'h200;
        bif.dm_req = 1'b1; bif.dm_we = 1'b0; bif.dm_addr = 32'h500;
        bif.dm_size = 2'b10; bif.dm_sign = 1'b0;
        ng = 0; nd = 0;
        for (int i = 0; i < 80 && nd < 6; i++) begin
            @(negedge clk);
            if_granted = 1'b0;
            if (bif.dm_gnt || bif.if_gnt) begin
                chk($sformatf("grant_%0d_is_fetch", ng), 32'(bif.if_gnt), 32'(ng == 4));
                if (bif.if_gnt) begin
                    if_q.push_back(32'hCAFE_0013);
                    if_granted = 1'b1;
                end else begin
                    dm_exp_t e;
                    e.data = 32'hCAFE_0013;
                    e.mis  = 1'b0;
                    dm_q.push_back(e);
                    nd++;
                end
                ng++;
            end
            @(posedge clk);
            #1;
            if (if_granted) bif.if_req = 1'b0;
            if (nd == 6) bif.dm_req = 1'b0;
        end
        chk("starve_total_grants", 32'(ng), 32'd7);
        drain();

        // signed and unsigned byte load from the top lane
        dm_acc(1'b0, 32'h203, 2'b00, 1'b1, 32'h0, 32'h80FF_FFFF, 32'hFFFF_FF80, 1'b0);
        chk("lb_be", 32'(last_be), 32'b1000);
        chk("lb_addr", last_addr, 32'h200);
        chk("lb_latency", 32'(dm_rv_cyc - gnt_cyc), 32'd2);
        dm_acc(1'b0, 32'h203, 2'b00, 1'b0, 32'h0, 32'h80FF_FFFF, 32'h0000_0080, 1'b0);

        // halfword store to the upper lanes
        dm_acc(1'b1, 32'h302, 2'b01, 1'b0, 32'h1234_ABCD, 32'hFFFF_FFFF, 32'h0, 1'b0);
        chk("sh_be", 32'(last_be), 32'b1100);
        chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(last_we), 32'd1);
        chk("sh_addr", last_addr, 32'h300);

        // misaligned word and half: no bus cycle, error response one cycle after grant
        bc0 = bus_cycles;
        dm_acc(1'b0, 32'h401, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1);
        chk("lw_mis_no_bus", 32'(bus_cycles - bc0), 32'd0);
        chk("lw_mis_latency", 32'(dm_rv_cyc - gnt_cyc), 32'd1);
        bc0 = bus_cycles;
        dm_acc(1'b0, 32'h401, 2'b01, 1'b1, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1);
        chk("lh_mis_no_bus", 32'(bus_cycles - bc0), 32'd0);
        chk("lh_mis_latency", 32'(dm_rv_cyc - gnt_cyc), 32'd1);

        // signed halfword from upper lanes with two wait states
        ack_wait = 2;
        dm_acc(1'b0, 32'h702, 2'b01, 1'b1, 32'h0, 32'h8001_1234, 32'hFFFF_8001, 1'b0);
        chk("lh_wait_latency", 32'(dm_rv_cyc - gnt_cyc), 32'd4);
        chk("lh_wait_be", 32'(last_be), 32'b1100);

        // reset during a wait state abandons the load
        ack_wait = 3;
        rv0 = dm_rv_count;
        @(posedge clk);
        #1;
        slave_rdata = 32'h0000_0055;
        bif.dm_req = 1'b1; bif.dm_we = 1'b0; bif.dm_addr = 32'h600;
        bif.dm_size = 2'b10; bif.dm_sign = 1'b0;
        wait_gnt(1'b1);
        @(posedge clk);
        #1 bif.dm_req = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_mid_busreq_before", 32'(bif.bus_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_busreq_async", 32'(bif.bus_req), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
        repeat (6) @(negedge clk);
        chk("rst_mid_no_rvalid", 32'(dm_rv_count - rv0), 32'd0);
        ack_wait = 0;
        dm_acc(1'b0, 32'h604, 2'b10, 1'b0, 32'h0, 32'h0000_0099, 32'h0000_0099, 1'b0);
        chk("post_rst_latency", 32'(dm_rv_cyc - gnt_cyc), 32'd2);

        chk("sb_if_empty", 32'(if_q.size()), 32'd0);
        chk("sb_dm_empty", 32'(dm_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
